// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Streams a program into the CPU instruction RAM while holding the CPU
// pipeline in reset, then releases it so the core fetches from PC 0.
//
// Parameters:
//   ADDR_W  RAM address width (matches the PC)
//   DATA_W  instruction width
//   DEPTH   number of program words the loader may write (1..2^ADDR_W)
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   load_start_i            begin a load (honoured in IDLE only)
//   in_valid_i/in_data_i    instruction word stream
//   in_ready_o              word can be accepted this cycle (combinational)
//   load_done_i             source has sent its last word (honoured in LOAD)
//   mem_addr_o/mem_data_o   RAM write address/data
//   mem_wren_o              RAM write strobe, one cycle per word
//   cpu_resetn_o            active-low reset to the CPU pipeline
//   busy_o                  loader not idle (combinational)
//   word_count_o            words accepted in the current or last load
//   overflow_o              sticky: a word was offered while the region was full
//
// Build option:
//   INSTR_LOADER_NOP_FILL_EN  when defined, unused program space above the
//                             loaded words is overwritten with 8'h00 (NOP)
//                             before the CPU is released.
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              load_done_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_wren_o,
  output logic              cpu_resetn_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] word_count_o,
  output logic              overflow_o
);

  // One extra bit so the count can represent DEPTH == 2^ADDR_W.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef INSTR_LOADER_NOP_FILL_EN
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_RELEASE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              cpu_resetn_q, cpu_resetn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
`ifdef INSTR_LOADER_NOP_FILL_EN
  logic [CW-1:0]     fill_q, fill_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      cpu_resetn_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
`ifdef INSTR_LOADER_NOP_FILL_EN
      fill_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      cpu_resetn_q <= cpu_resetn_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
`ifdef INSTR_LOADER_NOP_FILL_EN
      fill_q       <= fill_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    cpu_resetn_d = cpu_resetn_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    in_ready_o   = 1'b0;
`ifdef INSTR_LOADER_NOP_FILL_EN
    fill_d       = fill_q;
`endif
    case (state_q)
      S_IDLE: begin
        cpu_resetn_d = 1'b1;
        if (load_start_i) begin
          state_d      = S_LOAD;
          count_d      = '0;
          overflow_d   = 1'b0;
          cpu_resetn_d = 1'b0;
        end
      end
      S_LOAD: begin
        cpu_resetn_d = 1'b0;
        in_ready_o   = (count_q < DEPTH_C);
        if (in_valid_i && in_ready_o) begin
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = in_data_i;
          wren_d  = 1'b1;
          count_d = count_q + CW'(1);
        end else if (in_valid_i) begin
          overflow_d = 1'b1;
        end
        // A word offered alongside load_done is written first, so the
        // transition decision uses the post-write count.
        if (load_done_i) begin
`ifdef INSTR_LOADER_NOP_FILL_EN
          if (count_d < DEPTH_C) begin
            state_d = S_FILL;
            fill_d  = count_d;
          end else begin
            state_d = S_RELEASE;
          end
`else
          state_d = S_RELEASE;
`endif
        end
      end
`ifdef INSTR_LOADER_NOP_FILL_EN
      S_FILL: begin
        addr_d = fill_q[ADDR_W-1:0];
        data_d = '0;
        wren_d = 1'b1;
        fill_d = fill_q + CW'(1);
        if (fill_q == LAST_C) state_d = S_RELEASE;
      end
`endif
      S_RELEASE: begin
        state_d      = S_IDLE;
        cpu_resetn_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign mem_wren_o   = wren_q;
  assign cpu_resetn_o = cpu_resetn_q;
  assign word_count_o = count_q[ADDR_W-1:0];
  assign overflow_o   = overflow_q;

endmodule
